cwt_scale_restore: RTL

Streaming power-of-two rescaler that reverses the per-scale right-shift applied to wavelet coefficients. Each sample is multiplied by 2^shift with signed saturation, so coefficients from different scales return to a common magnitude range before accumulation or output. It is a 2-stage valid/ready pipeline between the coefficient datapath and the result sink, and it keeps a running count of saturated samples.

---
 rtl/cwt_scale_restore.sv | 113 +++++++++++
 1 files changed

// File: rtl/cwt_scale_restore.sv
// cwt_scale_restore: two-stage valid/ready pipeline that multiplies each signed
// wavelet coefficient by 2^shift with signed saturation. It also keeps a
// saturating count of clipped samples that have been delivered.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input handshake (in_ready is combinational from out_ready)
//   in_data, in_shift          signed sample and left-shift amount
//   out_valid/out_ready        output handshake
//   out_data, out_sat          rescaled sample and clip flag (registered)
//   clear_count                synchronous clear of sat_count (wins over an increment)
//   sat_count                  clipped-sample count, holds at all-ones
module cwt_scale_restore #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned SHIFT_WIDTH = 3,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [SHIFT_WIDTH-1:0] in_shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_sat,
   input  logic                   clear_count,
   output logic [CNT_WIDTH-1:0]   sat_count
);

   // Full-precision product width, and the bits that must all match the sign
   // bit for the product to fit in DATA_WIDTH.
   localparam int unsigned FULL_WIDTH = DATA_WIDTH + (2 ** SHIFT_WIDTH) - 1;
   localparam int unsigned HEAD_WIDTH = FULL_WIDTH - DATA_WIDTH + 1;

   logic                          s1_full;
   logic signed [DATA_WIDTH-1:0]  s1_data;
   logic [SHIFT_WIDTH-1:0]        s1_shift;

   logic                          in_xfer_c;
   logic                          out_xfer_c;
   logic                          s2_adv_c;
   logic                          s1_adv_c;
   logic signed [FULL_WIDTH-1:0]  prod_c;
   logic [HEAD_WIDTH-1:0]         head_c;
   logic                          sat_c;
   logic [DATA_WIDTH-1:0]         res_c;

   // Handshake and stage-advance conditions.
   assign out_xfer_c = out_valid & out_ready;
   assign s2_adv_c   = ~out_valid | out_ready;
   assign s1_adv_c   = s1_full & s2_adv_c;
   assign in_ready   = ~rst & (~s1_full | s2_adv_c);
   assign in_xfer_c  = in_valid & in_ready;

   // Sign-extended shift, then clip when the head bits are not a pure sign run.
   always_comb begin
      prod_c = '0;
      head_c = '0;
      sat_c  = 1'b0;
      res_c  = '0;
      prod_c = FULL_WIDTH'(s1_data) <<< s1_shift;
      head_c = prod_c[FULL_WIDTH-1:DATA_WIDTH-1];
      sat_c  = ~((&head_c) | ~(|head_c));
      if (sat_c) begin
         res_c = prod_c[FULL_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         res_c = prod_c[DATA_WIDTH-1:0];
      end
   end

   // Stage 1: capture input; a simultaneous move-out and refill keeps it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_full  <= 1'b0;
         s1_data  <= '0;
         s1_shift <= '0;
      end else if (in_xfer_c) begin
         s1_full  <= 1'b1;
         s1_data  <= in_data;
         s1_shift <= in_shift;
      end else if (s1_adv_c) begin
         s1_full  <= 1'b0;
      end
   end

   // Stage 2: registered result; holds while the sink stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_adv_c) begin
         out_valid <= s1_full;
         if (s1_full) begin
            out_data <= res_c;
            out_sat  <= sat_c;
         end
      end
   end

   // Clipped-output counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clear_count) begin
         sat_count <= '0;
      end else if (out_xfer_c && out_sat && (sat_count != '1)) begin
         sat_count <= sat_count + CNT_WIDTH'(1);
      end
   end

endmodule
